// File: rtl/fc_layer6.sv
// Layer-6 fully connected stage: 120-in / 84-out with one time-multiplexed MAC and external weight/bias ROMs.
// Define FC_RELU_EN to clamp negative results to zero (ReLU); leave it undefined for a linear output.
module fc_layer6 #(
    parameter int INPUT_NUM        = 120,
    parameter int OUTPUT_NUM       = 84,
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 1,
    parameter int ACC_WIDTH        = 40,
    parameter int W_ADDR_WIDTH     = 14,
    parameter int B_ADDR_WIDTH     = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*INPUT_NUM-1:0]  input_data,
    input  logic                             input_valid,
    output logic                             in_ready,
    output logic [W_ADDR_WIDTH-1:0]          weight_addr,
    input  logic [DATA_WIDTH-1:0]            weight_data,
    output logic [B_ADDR_WIDTH-1:0]          bias_addr,
    input  logic [DATA_WIDTH-1:0]            bias_data,
    output logic                             out_valid,
    output logic [DATA_WIDTH*OUTPUT_NUM-1:0] out_data
);

    localparam int FRAC_BITS = DATA_WIDTH - 1 - WEIGHT_INT_WIDTH;
    localparam int CW        = $clog2(INPUT_NUM + 2);
    localparam int OW        = $clog2(OUTPUT_NUM);
    localparam int IW        = $clog2(INPUT_NUM);
    localparam int SW        = ACC_WIDTH + 1;

    localparam logic [CW-1:0] C_ZERO      = CW'(0);
    localparam logic [CW-1:0] C_BIAS_ADDR = CW'(INPUT_NUM - 2);
    localparam logic [CW-1:0] C_LAST_W    = CW'(INPUT_NUM - 1);
    localparam logic [CW-1:0] C_BIAS_REG  = CW'(INPUT_NUM);
    localparam logic [CW-1:0] C_WRITE     = CW'(INPUT_NUM + 1);
    localparam logic [OW-1:0] O_LAST      = OW'(OUTPUT_NUM - 1);

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state_r;
    state_t                           state_s;
    logic signed [DATA_WIDTH-1:0]     in_mem_r [INPUT_NUM];
    logic [CW-1:0]                    c_r;
    logic [OW-1:0]                    o_r;
    logic signed [ACC_WIDTH-1:0]      acc_r;
    logic signed [DATA_WIDTH-1:0]     bias_r;
    logic [W_ADDR_WIDTH-1:0]          weight_addr_r;
    logic [B_ADDR_WIDTH-1:0]          bias_addr_r;
    logic                             in_ready_r;
    logic                             out_valid_r;
    logic [DATA_WIDTH*OUTPUT_NUM-1:0] out_data_r;

    logic                             accept_s;
    logic                             last_neuron_s;
    logic [IW-1:0]                    mac_idx_s;
    logic signed [DATA_WIDTH-1:0]     in_elem_s;
    logic signed [2*DATA_WIDTH-1:0]   prod_s;
    logic signed [SW-1:0]             bias_ext_s;
    logic signed [SW-1:0]             sum_s;
    logic signed [SW-1:0]             shifted_s;
    logic signed [DATA_WIDTH-1:0]     sat_s;
    logic signed [DATA_WIDTH-1:0]     result_s;

    assign accept_s      = input_valid && in_ready_r;
    assign last_neuron_s = (o_r == O_LAST);

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign weight_addr = weight_addr_r;
    assign bias_addr   = bias_addr_r;

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if ((c_r == C_WRITE) && last_neuron_s) state_s = DONE;
                else                                   state_s = RUN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // MAC operand select, then bias alignment, truncating shift, saturation and optional ReLU.
    always_comb begin
        mac_idx_s = '0;
        if ((c_r != C_ZERO) && (c_r <= C_BIAS_REG)) mac_idx_s = IW'(c_r - CW'(1));
        else                                        mac_idx_s = '0;
        in_elem_s  = in_mem_r[mac_idx_s];
        prod_s     = in_elem_s * $signed(weight_data);
        bias_ext_s = SW'(bias_r) <<< FRAC_BITS;
        sum_s      = SW'(acc_r) + bias_ext_s;
        shifted_s  = sum_s >>> FRAC_BITS;
        if (shifted_s > SAT_MAX)      sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (shifted_s < SAT_MIN) sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                          sat_s = shifted_s[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
        if (sat_s[DATA_WIDTH-1]) result_s = '0;
        else                     result_s = sat_s;
`else
        result_s = sat_s;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Input vector capture; contents only matter after an accept, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                in_mem_r[i] <= input_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Per-neuron schedule: address generation, accumulate, bias capture and result write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            weight_addr_r <= '0;
            bias_addr_r   <= '0;
            acc_r         <= '0;
            bias_r        <= '0;
            c_r           <= '0;
            o_r           <= '0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_r == RUN) && (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        weight_addr_r <= '0;
                        acc_r         <= '0;
                        c_r           <= '0;
                        o_r           <= '0;
                    end
                end
                RUN: begin
                    if (c_r == C_WRITE) begin
                        c_r <= '0;
                        out_data_r[o_r*DATA_WIDTH +: DATA_WIDTH] <= result_s;
                        if (!last_neuron_s) o_r <= o_r + OW'(1);
                    end else begin
                        c_r <= c_r + CW'(1);
                    end
                    if (c_r == C_ZERO)          acc_r <= '0;
                    else if (c_r <= C_BIAS_REG) acc_r <= acc_r + ACC_WIDTH'(prod_s);
                    if (c_r == C_BIAS_ADDR) bias_addr_r <= B_ADDR_WIDTH'(o_r);
                    if (c_r == C_BIAS_REG)  bias_r <= $signed(bias_data);
                    // Address holds over the two tail cycles, then jumps to the next neuron's row.
                    if ((c_r < C_LAST_W) || ((c_r == C_WRITE) && !last_neuron_s))
                        weight_addr_r <= weight_addr_r + W_ADDR_WIDTH'(1);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer6.sv
// Directed self-checking bench for fc_layer6: reset, MAC, address schedule, saturation/ReLU,
// busy-ignore with re-accept, and reset in the middle of a run.
module tb_fc_layer6;

    localparam int IN_N    = 120;
    localparam int OUT_N   = 84;
    localparam int DW      = 16;
    localparam int RUN_CYC = OUT_N * (IN_N + 2);
    localparam int LAT     = RUN_CYC + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [DW*IN_N-1:0]  input_data;
    logic                input_valid;
    logic                in_ready;
    logic [13:0]         weight_addr;
    logic [15:0]         weight_data;
    logic [6:0]          bias_addr;
    logic [15:0]         bias_data;
    logic                out_valid;
    logic [DW*OUT_N-1:0] out_data;

    int total = 0;
    int bad   = 0;
    logic signed [15:0] w_val = 16'sd0;
    logic signed [15:0] b_val = 16'sd0;
    logic signed [15:0] neg_exp;
    logic signed [15:0] busy2_exp;
    int lat;

    fc_layer6 dut (
        .clk         (clk),
        .rst         (rst),
        .input_data  (input_data),
        .input_valid (input_valid),
        .in_ready    (in_ready),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .bias_addr   (bias_addr),
        .bias_data   (bias_data),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models with one-cycle read latency; each test uses a uniform weight and bias.
    always @(posedge clk) begin
        weight_data <= w_val;
        bias_data   <= b_val;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic signed [15:0] exp);
        for (int k = 0; k < OUT_N; k++) begin
            check($sformatf("%s[%0d]", tag, k), $signed(out_data[k*DW +: DW]), exp);
        end
    endtask

    function automatic logic [DW*IN_N-1:0] one_hot(input int idx, input logic [15:0] v);
        logic [DW*IN_N-1:0] vec;
        vec = '0;
        vec[idx*DW +: DW] = v;
        return vec;
    endfunction

    function automatic logic [DW*IN_N-1:0] all_val(input logic [15:0] v);
        logic [DW*IN_N-1:0] vec;
        for (int i = 0; i < IN_N; i++) vec[i*DW +: DW] = v;
        return vec;
    endfunction

    // Called in an IDLE cycle with input_valid set; the next edge is the accept edge.
    // Returns in the out_valid cycle (cycle index counted from 1 after the accept edge).
    task automatic run_check(input string tag, input bit keep_valid, input bit churn, output int lat_o);
        int addr_err  = 0;
        int bias_err  = 0;
        int ready_err = 0;
        int o;
        int c;
        int exp_w;
        lat_o = -1;
        tick();
        if (!keep_valid) input_valid = 1'b0;
        for (int cyc = 1; cyc <= LAT + 10; cyc++) begin
            if (in_ready !== 1'b0) ready_err++;
            if (out_valid === 1'b1) begin
                lat_o = cyc;
                break;
            end
            if (cyc <= RUN_CYC) begin
                o = (cyc - 1) / (IN_N + 2);
                c = (cyc - 1) % (IN_N + 2);
                exp_w = o * IN_N + ((c < IN_N) ? c : IN_N - 1);
                if (weight_addr !== 14'(exp_w)) addr_err++;
                if ((c == IN_N - 1) && (bias_addr !== 7'(o))) bias_err++;
            end
            if (churn) begin
                for (int i = 0; i < (DW * IN_N) / 32; i++) input_data[i*32 +: 32] = $urandom;
            end
            tick();
        end
        check({tag, " latency"}, lat_o, LAT);
        check({tag, " weight_addr errors"}, addr_err, 0);
        check({tag, " bias_addr errors"}, bias_err, 0);
        check({tag, " in_ready high while busy"}, ready_err, 0);
    endtask

    initial begin
`ifdef FC_RELU_EN
        neg_exp   = 16'sd0;
        busy2_exp = 16'sd0;
`else
        neg_exp   = -16'sd32768;
        busy2_exp = -16'sd4096;
`endif
        rst         = 1'b1;
        input_valid = 1'b0;
        input_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset weight_addr", weight_addr, 0);
        check("reset bias_addr", bias_addr, 0);
        check_all("reset out_data", 16'sd0);
        rst = 1'b0;
        tick();

        // 1.0 * 0.5 + 0.25 = 0.75
        w_val = 16'sd8192;
        b_val = 16'sd4096;
        input_data  = one_hot(0, 16'd16384);
        input_valid = 1'b1;
        run_check("basic", 1'b0, 1'b0, lat);
        check_all("basic out", 16'sd12288);
        tick();
        check("basic ready after done", in_ready, 1);
        check("basic valid after done", out_valid, 0);
        check_all("basic held", 16'sd12288);

        w_val = 16'sd16384;
        b_val = 16'sd0;
        input_data  = all_val(16'd16384);
        input_valid = 1'b1;
        run_check("sat_pos", 1'b0, 1'b0, lat);
        check_all("sat_pos out", 16'sd32767);
        tick();

        w_val = -16'sd16384;
        input_data  = all_val(16'd16384);
        input_valid = 1'b1;
        run_check("sat_neg", 1'b0, 1'b0, lat);
        check_all("sat_neg out", neg_exp);
        tick();

        // input_valid stays high; data churns while busy and must be ignored.
        w_val = 16'sd8192;
        b_val = 16'sd4096;
        input_data  = one_hot(0, 16'd16384);
        input_valid = 1'b1;
        run_check("busy1", 1'b1, 1'b1, lat);
        check_all("busy1 out", 16'sd12288);
        input_data = one_hot(1, 16'hC000);
        tick();
        check("busy idle in_ready", in_ready, 1);
        run_check("busy2", 1'b1, 1'b0, lat);
        input_valid = 1'b0;
        check_all("busy2 out", busy2_exp);
        tick();

        input_data  = one_hot(0, 16'd16384);
        input_valid = 1'b1;
        tick();
        input_valid = 1'b0;
        repeat (499) tick();
        check("midrun busy", in_ready, 0);
        rst = 1'b1;
        #2;
        check("midrun rst in_ready", in_ready, 1);
        check("midrun rst out_valid", out_valid, 0);
        check("midrun rst weight_addr", weight_addr, 0);
        check("midrun rst bias_addr", bias_addr, 0);
        check_all("midrun rst out_data", 16'sd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("post-reset no out_valid", out_valid, 0);

        // 1.0 * 1.0 - 0.5 = 0.5, driven through the last input element.
        w_val = 16'sd16384;
        b_val = -16'sd8192;
        input_data  = one_hot(IN_N - 1, 16'd16384);
        input_valid = 1'b1;
        run_check("post_reset", 1'b0, 1'b0, lat);
        check_all("post_reset out", 16'sd8192);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_layer6.md
Name: fc_layer6

Overview:
- Fully connected stage directly downstream of the Layer-5 convolution.
- Consumes its 120-element output vector and produces the 84-element Layer-6 vector for the final classifier.
- Uses one time-multiplexed MAC. Weights and biases are read from external synchronous ROMs, one word per cycle.
- The result vector is registered and flagged with a single-cycle out_valid pulse.

Parameters:
- INPUT_NUM, 120, number of input activations.
- OUTPUT_NUM, 84, number of output neurons.
- DATA_WIDTH, 16, width of activations, weights and biases (signed two's complement).
- WEIGHT_INT_WIDTH, 1, integer bits excluding sign. FRAC_BITS = DATA_WIDTH-1-WEIGHT_INT_WIDTH (14), so 1.0 = 16384.
- ACC_WIDTH, 40, accumulator width.
- W_ADDR_WIDTH, 14, weight address width, must satisfy 2^W_ADDR_WIDTH >= INPUT_NUM*OUTPUT_NUM.
- B_ADDR_WIDTH, 7, bias address width, must satisfy 2^B_ADDR_WIDTH >= OUTPUT_NUM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_data  in  DATA_WIDTH*INPUT_NUM  input vector; element i is at [DATA_WIDTH*i +: DATA_WIDTH].
- input_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- weight_addr  out  W_ADDR_WIDTH  weight ROM address.
- weight_data  in  DATA_WIDTH  weight ROM data, 1-cycle read latency.
- bias_addr  out  B_ADDR_WIDTH  bias ROM address.
- bias_data  in  DATA_WIDTH  bias ROM data, 1-cycle read latency.
- out_valid  out  1  one-cycle result pulse.
- out_data  out  DATA_WIDTH*OUTPUT_NUM  result vector; element o is at [DATA_WIDTH*o +: DATA_WIDTH].

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, weight_addr=0, bias_addr=0, accumulator=0, counters o=i=0.
- Accept:
  - Occurs on a rising edge where input_valid && in_ready.
  - input_data is captured into an internal INPUT_NUM×DATA_WIDTH register in that cycle.
  - input_valid while in_ready=0 is ignored; there is no buffering.
- in_ready is 1 only in IDLE.
- FSM states: IDLE -> RUN (on accept) -> DONE (after the last neuron) -> IDLE. DONE lasts exactly one cycle.
- RUN schedule, per neuron o, using local cycle c = 0..INPUT_NUM+1:
  - c=0..INPUT_NUM-1: drive weight_addr = o*INPUT_NUM + c.
  - c=INPUT_NUM-1: drive bias_addr = o.
  - c=1..INPUT_NUM: acc += input[c-1] * weight_data (full-precision 2*DATA_WIDTH product, sign-extended to ACC_WIDTH). Accumulator is cleared at c=0.
  - c=INPUT_NUM: bias_data is registered.
  - c=INPUT_NUM+1: write out_data[o] = sat16((acc + (bias <<< FRAC_BITS)) >>> FRAC_BITS).
    - Arithmetic shift truncates toward -inf; there is no rounding.
    - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - The optional activation is then applied.
  - Each neuron takes INPUT_NUM+2 cycles.
- Latency: out_valid is high for exactly one cycle, OUTPUT_NUM*(INPUT_NUM+2)+1 rising edges after the accept edge. With defaults this is 10249.
- out_data:
  - Elements update in place as they are written.
  - The full vector is valid from the out_valid cycle and held until a later accept overwrites elements.
- Address outputs hold their last value outside RUN.
- Reset asserted at any time:
  - Aborts immediately and restores all reset values.
  - No out_valid is produced for the aborted vector.
- Simultaneous input_valid and out_valid cannot cause an accept, because in_ready=0 in DONE. The earliest re-accept is the cycle after DONE.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: each saturated result < 0 is written as 0 (ReLU), matching the previous stage's activation.
- Undefined: the saturated result is written unchanged (linear output, e.g. for a logit layer).
- Timing is identical in both builds.

Test Plan:
- Reset check: assert rst for 3 cycles -> in_ready=1, out_valid=0, all out_data=0, weight_addr=0, bias_addr=0.
- Basic MAC, both builds:
  - Stimulus: input[0]=16384 (1.0), other inputs 0; all weights 8192 (0.5); all biases 4096 (0.25).
  - Expected: every out_data element = 12288 (0.75); out_valid exactly 10249 edges after accept; in_ready=0 throughout.
- Address sequence: ROM model logs addresses -> weight_addr steps 0..10079 contiguous, 120 per neuron, 2-cycle gap between neurons. bias_addr = o, driven at c=119 of each neuron.
- Saturation/ReLU:
  - Stimulus: all inputs 16384.
  - Weights 16384, bias 0 -> 32767.
  - Weights -16384, bias 0 -> -32768 with FC_RELU_EN undefined; 0 with FC_RELU_EN defined.
- Busy-ignore and re-accept:
  - Stimulus: input_valid held high continuously with changing data.
  - Expected: only the vector at the accept edge is used; a second accept occurs on the cycle after DONE; the second result is correct.
- Reset mid-run: assert rst at cycle 500 after accept -> out_data=0, no out_valid pulse; a new accept afterwards completes with full 10249-cycle latency and correct values.
